// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the serial arithmetic blocks.
package serial_arith_pkg;

    localparam int SERIAL_SUB_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/one_bit_full_subtractor.sv
// Combinational one-bit full subtractor: d = x - y - bin, with borrow-out.
module one_bit_full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module bit_serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_r;
    state_t             state_nx_s;
    logic [WIDTH-1:0]   a_sr_r;
    logic [WIDTH-1:0]   b_sr_r;
    logic [WIDTH-2:0]   diff_sr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               brw_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   diff_r;
    logic               bout_r;
    logic               d_s;
    logic               brw_nx_s;
    logic               accept_s;
    logic               last_s;
    logic [WIDTH-1:0]   diff_nx_s;

    one_bit_full_subtractor u_fs (
        .x    (a_sr_r[0]),
        .y    (b_sr_r[0]),
        .bin  (brw_r),
        .d    (d_s),
        .bout (brw_nx_s)
    );

    assign accept_s  = in_valid & in_ready_r;
    assign last_s    = (cnt_r == CNT_W'(WIDTH - 1));
    assign diff_nx_s = {d_s, diff_sr_r};

    // Next-state logic for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nx_s = SHIFT;
                else          state_nx_s = IDLE;
            end
            SHIFT: begin
                if (last_s) state_nx_s = DONE;
                else        state_nx_s = SHIFT;
            end
            DONE: begin
                if (out_ready) state_nx_s = IDLE;
                else           state_nx_s = DONE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
        end
    end

    // Operand shift registers, borrow flop, bit counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r    <= {WIDTH{1'b0}};
            b_sr_r    <= {WIDTH{1'b0}};
            diff_sr_r <= {(WIDTH-1){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            brw_r     <= 1'b0;
            diff_r    <= {WIDTH{1'b0}};
            bout_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_sr_r <= a;
                        b_sr_r <= b;
                        brw_r  <= bin;
                        cnt_r  <= {CNT_W{1'b0}};
                    end
                end
                SHIFT: begin
                    a_sr_r    <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r    <= {1'b0, b_sr_r[WIDTH-1:1]};
                    diff_sr_r <= diff_nx_s[WIDTH-1:1];
                    brw_r     <= brw_nx_s;
                    // Counter parks on the last bit rather than wrapping.
                    if (last_s) begin
                        diff_r <= diff_nx_s;
                        bout_r <= brw_nx_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    diff_r <= diff_r;
                end
                default: begin
                    brw_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_r;
    logic b_msb_r;
    logic ovf_r;

    // Signed overflow: operand signs differ and the result sign differs from a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (state_r == IDLE && accept_s) begin
                a_msb_r <= a[WIDTH-1];
                b_msb_r <= b[WIDTH-1];
            end
            if (state_r == SHIFT && last_s) begin
                ovf_r <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
            end
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign bout      = bout_r;

endmodule
